// File: rtl/axi3_ledreg_m.sv
// axi3_ledreg_m: AXI3 slave with LED, scratch, free-running cycle counter and ID registers.
module axi3_ledreg_m #(
  parameter logic [31:0] ID_VALUE  = 32'h5A7C_0001,
  parameter logic [7:0]  LED_RESET = 8'h55
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [11:0] i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [3:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  input  logic        i_wvalid,
  output logic        o_wready,
  input  logic [11:0] i_wid,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wlast,
  output logic        o_bvalid,
  input  logic        i_bready,
  output logic [11:0] o_bid,
  output logic [1:0]  o_bresp,
  input  logic        i_arvalid,
  output logic        o_arready,
  input  logic [11:0] i_arid,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic [11:0] o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic [7:0]  o_led
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    r_wstate;
  r_state_t    r_rstate;
  logic [31:0] r_waddr, r_raddr, r_scratch, r_cycles;
  logic [3:0]  r_awlen, r_arlen, r_wcnt, r_rcnt;
  logic [2:0]  r_awsize, r_arsize;
  logic [1:0]  r_awburst, r_arburst;
  logic        r_berr;

  logic        w_wbeat, w_wfinal, w_werr, w_wok, w_lerr;
  logic [31:0] w_wmask, w_rnext, w_laddr, w_ldata;
  logic [2:0]  w_lsize;
  logic [1:0]  w_lburst;

  // o_bid doubles as the latched AW id for the per-beat WID check
  assign w_wbeat  = o_wready & i_wvalid;
  assign w_wfinal = r_wcnt == r_awlen;
  assign w_werr   = (i_wid != o_bid) | (r_awsize != 3'b010) | (r_awburst == 2'b11) |
                    (r_waddr[11:4] != 8'd0) | r_waddr[3] | (i_wlast != w_wfinal);
  assign w_wok    = w_wbeat & ~w_werr;
  assign w_wmask  = {{8{i_wstrb[3]}}, {8{i_wstrb[2]}}, {8{i_wstrb[1]}}, {8{i_wstrb[0]}}};

  // Read data is captured on the loading edge, so a concurrent write shows up only on later beats
  assign w_rnext  = (r_arburst == 2'b00) ? r_raddr : r_raddr + 32'd4;
  assign w_laddr  = (r_rstate == R_IDLE) ? i_araddr : w_rnext;
  assign w_lsize  = (r_rstate == R_IDLE) ? i_arsize : r_arsize;
  assign w_lburst = (r_rstate == R_IDLE) ? i_arburst : r_arburst;
  assign w_lerr   = (w_lsize != 3'b010) | (w_lburst == 2'b11) | (w_laddr[11:4] != 8'd0);
  assign w_ldata  = w_lerr ? 32'd0 :
                    (w_laddr[3:2] == 2'd0) ? {24'd0, o_led} :
                    (w_laddr[3:2] == 2'd1) ? r_scratch :
                    (w_laddr[3:2] == 2'd2) ? r_cycles : ID_VALUE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_led     <= LED_RESET;
      r_scratch <= 32'd0;
      r_cycles  <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_wok && r_waddr[3:2] == 2'd0 && i_wstrb[0]) o_led <= i_wdata[7:0];
      if (w_wok && r_waddr[3:2] == 2'd1) r_scratch <= (r_scratch & ~w_wmask) | (i_wdata & w_wmask);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate  <= W_IDLE;
      o_awready <= 1'b0;
      o_wready  <= 1'b0;
      o_bvalid  <= 1'b0;
      o_bid     <= 12'd0;
      o_bresp   <= 2'b00;
      r_waddr   <= 32'd0;
      r_awlen   <= 4'd0;
      r_awsize  <= 3'd0;
      r_awburst <= 2'd0;
      r_wcnt    <= 4'd0;
      r_berr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE:
          if (o_awready && i_awvalid) begin
            o_awready <= 1'b0;
            o_wready  <= 1'b1;
            o_bid     <= i_awid;
            r_waddr   <= i_awaddr;
            r_awlen   <= i_awlen;
            r_awsize  <= i_awsize;
            r_awburst <= i_awburst;
            r_wcnt    <= 4'd0;
            r_berr    <= 1'b0;
            r_wstate  <= W_DATA;
          end else o_awready <= 1'b1;
        W_DATA:
          if (w_wbeat) begin
            r_wcnt  <= r_wcnt + 4'd1;
            r_waddr <= (r_awburst == 2'b00) ? r_waddr : r_waddr + 32'd4;
            r_berr  <= r_berr | w_werr;
            if (w_wfinal) begin
              o_wready <= 1'b0;
              o_bvalid <= 1'b1;
              o_bresp  <= (r_berr | w_werr) ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end
          end
        W_RESP:
          if (i_bready) begin
            o_bvalid  <= 1'b0;
            o_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rstate  <= R_IDLE;
      o_arready <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rlast   <= 1'b0;
      o_rid     <= 12'd0;
      o_rdata   <= 32'd0;
      o_rresp   <= 2'b00;
      r_raddr   <= 32'd0;
      r_arlen   <= 4'd0;
      r_arsize  <= 3'd0;
      r_arburst <= 2'd0;
      r_rcnt    <= 4'd0;
    end else begin
      case (r_rstate)
        R_IDLE:
          if (o_arready && i_arvalid) begin
            o_arready <= 1'b0;
            o_rvalid  <= 1'b1;
            o_rid     <= i_arid;
            o_rlast   <= i_arlen == 4'd0;
            o_rdata   <= w_ldata;
            o_rresp   <= w_lerr ? 2'b10 : 2'b00;
            r_raddr   <= i_araddr;
            r_arlen   <= i_arlen;
            r_arsize  <= i_arsize;
            r_arburst <= i_arburst;
            r_rcnt    <= 4'd0;
            r_rstate  <= R_DATA;
          end else o_arready <= 1'b1;
        R_DATA:
          if (i_rready) begin
            if (o_rlast) begin
              o_rvalid  <= 1'b0;
              o_rlast   <= 1'b0;
              o_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rcnt  <= r_rcnt + 4'd1;
              o_rlast <= (r_rcnt + 4'd1) == r_arlen;
              o_rdata <= w_ldata;
              o_rresp <= w_lerr ? 2'b10 : 2'b00;
            end
          end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi3_ledreg_m.sv
// tb_axi3_ledreg_m: randomized self-checking bench for axi3_ledreg_m against a register-map model.
module tb_axi3_ledreg_m;
  localparam logic [31:0] ID = 32'h5A7C_0001;

  logic        i_clk, i_rst_n;
  logic        i_awvalid, o_awready, i_wvalid, o_wready, i_wlast, o_bvalid, i_bready;
  logic        i_arvalid, o_arready, o_rvalid, i_rready, o_rlast;
  logic [11:0] i_awid, i_arid, i_wid, o_bid, o_rid;
  logic [31:0] i_awaddr, i_araddr, i_wdata, o_rdata;
  logic [3:0]  i_awlen, i_arlen, i_wstrb;
  logic [2:0]  i_awsize, i_arsize;
  logic [1:0]  i_awburst, i_arburst, o_bresp, o_rresp;
  logic [7:0]  o_led;

  int n_err = 0, n_chk = 0, tb_cyc = 0;
  int rd_cyc, rd_lat, wr_blat;
  logic [7:0]  led_after_w;
  logic [31:0] tb_wd [16];
  logic [3:0]  tb_ws [16];
  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  logic [11:0] rd_id [16];
  logic        st_v [5];
  logic [31:0] st_d [5];
  logic [1:0]  st_r [5];
  logic [7:0]  m_led;
  logic [31:0] m_scratch;

  axi3_ledreg_m dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
    .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wid(i_wid), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
    .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
    .o_rresp(o_rresp), .o_rlast(o_rlast), .o_led(o_led)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) tb_cyc <= tb_cyc + 1;

  function automatic logic sig(input int w);
    return w == 0 ? o_awready : w == 1 ? o_wready : w == 2 ? o_bvalid : w == 3 ? o_arready : o_rvalid;
  endfunction

  task automatic wait_hi(input int w, output int n);
    n = 0;
    while (!sig(w) && n < 100) begin @(posedge i_clk); #1; n++; end
    if (!sig(w)) begin
      n_chk++; n_err++;
      $display("FAIL timeout chan=%0d: still 0 after %0d cycles, need 1", w, n);
    end
  endtask

  task automatic handshake(input int w);
    int n;
    wait_hi(w, n);
    @(posedge i_clk); #1;
  endtask

  // Model: each beat is judged on its own, only clean beats touch the registers
  task automatic model_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [11:0] wid,
                             input bit bad_last, output logic [1:0] resp);
    logic [31:0] a;
    bit err, any;
    any = 0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + ((burst == 2'b00) ? 32'd0 : 32'(4 * b));
      err = (wid != id) || (size != 3'b010) || (burst == 2'b11) || (a[11:4] != 0) || (a[3:2] >= 2) || bad_last;
      any |= err;
      if (!err && a[3:2] == 0 && tb_ws[b][0]) m_led = tb_wd[b][7:0];
      if (!err && a[3:2] == 1)
        for (int j = 0; j < 4; j++) if (tb_ws[b][j]) m_scratch[8*j +: 8] = tb_wd[b][8*j +: 8];
    end
    resp = any ? 2'b10 : 2'b00;
  endtask

  function automatic logic [33:0] model_read(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    if (size != 3'b010 || burst == 2'b11 || a[11:4] != 0) return {2'b10, 32'd0};
    case (a[3:2])
      2'd0: return {2'b00, 24'd0, m_led};
      2'd1: return {2'b00, m_scratch};
      2'd2: return {2'b00, 32'd0};
      default: return {2'b00, ID};
    endcase
  endfunction

  task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [11:0] wid,
                          input bit bad_last, output logic [1:0] resp, output logic [11:0] bid);
    i_awvalid = 1; i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    handshake(0);
    i_awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      i_wvalid = 1; i_wid = wid; i_wdata = tb_wd[b]; i_wstrb = tb_ws[b];
      i_wlast = (b == int'(len)) ^ bad_last;
      handshake(1);
    end
    i_wvalid = 0; i_wlast = 0;
    led_after_w = o_led;
    wait_hi(2, wr_blat);
    resp = o_bresp; bid = o_bid;
    i_bready = 1;
    @(posedge i_clk); #1;
    i_bready = 0;
  endtask

  task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall);
    i_arvalid = 1; i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    handshake(3);
    i_arvalid = 0;
    rd_cyc = tb_cyc;
    for (int b = 0; b <= int'(len); b++) begin
      int n;
      wait_hi(4, n);
      if (b == 0) begin
        rd_lat = n;
        for (int k = 0; k < stall; k++) begin
          st_v[k] = o_rvalid; st_d[k] = o_rdata; st_r[k] = o_rresp;
          @(posedge i_clk); #1;
        end
      end
      rd_d[b] = o_rdata; rd_r[b] = o_rresp; rd_l[b] = o_rlast; rd_id[b] = o_rid;
      i_rready = 1;
      @(posedge i_clk); #1;
      i_rready = 0;
    end
  endtask

  task automatic test_reset;
    {i_awvalid, i_wvalid, i_wlast, i_bready, i_arvalid, i_rready} = '0;
    {i_awid, i_arid, i_wid, i_awaddr, i_araddr, i_wdata} = '0;
    {i_awlen, i_arlen, i_wstrb, i_awsize, i_arsize, i_awburst, i_arburst} = '0;
    i_rst_n = 1; #2; i_rst_n = 0;
    repeat (3) @(posedge i_clk);
    #1;
    n_chk++;
    if ({o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast} !== 6'b0 || o_bid !== 0 || o_rid !== 0 ||
        o_bresp !== 0 || o_rresp !== 0 || o_rdata !== 0) begin
      n_err++; $display("FAIL reset_outputs: got ctl=%b rdata=%h, need all zero",
                        {o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast}, o_rdata);
    end
    n_chk++;
    if (o_led !== 8'h55) begin n_err++; $display("FAIL reset_led: got %h need 55", o_led); end
    i_rst_n = 1;
    n_chk++;
    if ({o_awready, o_arready} !== 2'b00) begin n_err++; $display("FAIL ready_before_edge: got %b need 00", {o_awready, o_arready}); end
    @(posedge i_clk); #1;
    n_chk++;
    if ({o_awready, o_arready} !== 2'b11) begin n_err++; $display("FAIL ready_after_edge: got %b need 11", {o_awready, o_arready}); end
    m_led = 8'h55; m_scratch = 0;
  endtask

  task automatic test_id_read;
    do_read(12'h111, 32'h0000_000C, 0, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] !== ID || rd_r[0] !== 2'b00 || rd_l[0] !== 1'b1 || rd_id[0] !== 12'h111) begin
      n_err++; $display("FAIL id_read: got d=%h r=%b l=%b id=%h need %h 00 1 111", rd_d[0], rd_r[0], rd_l[0], rd_id[0], ID);
    end
    n_chk++;
    if (rd_lat !== 0) begin n_err++; $display("FAIL r_latency: got %0d extra cycles need 0", rd_lat); end
    do_read(12'h222, 32'h0000_0000, 0, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] !== 32'h0000_0055 || rd_r[0] !== 2'b00) begin n_err++; $display("FAIL led_read: got %h/%b need 00000055/00", rd_d[0], rd_r[0]); end
    do_read(12'h333, 32'hABCD_E00C, 0, 3'b010, 2'b00, 0);
    n_chk++;
    if (rd_d[0] !== ID) begin n_err++; $display("FAIL high_addr_ignored: got %h need %h", rd_d[0], ID); end
  endtask

  task automatic test_strobe;
    logic [1:0] resp, mresp;
    logic [11:0] bid;
    tb_wd[0] = 32'hDEADBEEF; tb_ws[0] = 4'b0101;
    model_write(12'h3A5, 32'h4, 0, 3'b010, 2'b01, 12'h3A5, 0, mresp);
    do_write(12'h3A5, 32'h4, 0, 3'b010, 2'b01, 12'h3A5, 0, resp, bid);
    n_chk++;
    if (resp !== mresp || bid !== 12'h3A5) begin n_err++; $display("FAIL strobe_bresp: got %b/%h need %b/3a5", resp, bid, mresp); end
    n_chk++;
    if (wr_blat !== 0) begin n_err++; $display("FAIL b_latency: got %0d extra cycles need 0", wr_blat); end
    do_read(12'h001, 32'h4, 0, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] !== 32'h00AD00EF) begin n_err++; $display("FAIL strobe_read: got %h need 00ad00ef", rd_d[0]); end
  endtask

  task automatic test_incr;
    logic [1:0] resp, mresp;
    logic [11:0] bid;
    tb_wd[0] = 32'h0000_00A5; tb_wd[1] = 32'h1234_5678; tb_ws[0] = 4'hF; tb_ws[1] = 4'hF;
    model_write(12'h022, 32'h0, 1, 3'b010, 2'b01, 12'h022, 0, mresp);
    do_write(12'h022, 32'h0, 1, 3'b010, 2'b01, 12'h022, 0, resp, bid);
    n_chk++;
    if (resp !== mresp || led_after_w !== 8'hA5) begin n_err++; $display("FAIL incr_write: got %b led=%h need %b led=a5", resp, led_after_w, mresp); end
    do_read(12'h033, 32'h0, 3, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] !== 32'hA5 || rd_d[1] !== 32'h1234_5678 || rd_d[3] !== ID || rd_r[2] !== 2'b00) begin
      n_err++; $display("FAIL incr_read: got %h %h %h need a5 12345678 %h", rd_d[0], rd_d[1], rd_d[3], ID);
    end
    n_chk++;
    if ({rd_l[0], rd_l[1], rd_l[2], rd_l[3]} !== 4'b0001) begin
      n_err++; $display("FAIL incr_rlast: got %b need 0001", {rd_l[0], rd_l[1], rd_l[2], rd_l[3]});
    end
  endtask

  task automatic test_errors;
    logic [31:0] ea [6] = '{32'h8, 32'h10, 32'h4, 32'h4, 32'h0, 32'h4};
    logic [2:0]  es [6] = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b010};
    logic [1:0]  eb [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01};
    bit          ew [6] = '{0, 0, 0, 1, 0, 0};
    bit          el [6] = '{0, 0, 0, 0, 0, 1};
    logic [1:0] resp, mresp;
    logic [11:0] bid;
    for (int i = 0; i < 6; i++) begin
      tb_wd[0] = $urandom; tb_ws[0] = 4'hF;
      model_write(12'h0C0, ea[i], 0, es[i], eb[i], ew[i] ? 12'h0C1 : 12'h0C0, el[i], mresp);
      do_write(12'h0C0, ea[i], 0, es[i], eb[i], ew[i] ? 12'h0C1 : 12'h0C0, el[i], resp, bid);
      n_chk++;
      if (resp !== 2'b10 || resp !== mresp) begin n_err++; $display("FAIL err_write%0d: got %b need 10", i, resp); end
    end
    do_read(12'h0, 32'h0, 1, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] !== {24'd0, m_led} || rd_d[1] !== m_scratch) begin
      n_err++; $display("FAIL err_unchanged: got %h %h need %h %h", rd_d[0], rd_d[1], m_led, m_scratch);
    end
    do_read(12'h0, 32'h0, 0, 3'b001, 2'b01, 0);
    n_chk++;
    if (rd_r[0] !== 2'b10 || rd_d[0] !== 0) begin n_err++; $display("FAIL err_read_size: got %b/%h need 10/0", rd_r[0], rd_d[0]); end
    do_read(12'h0, 32'h10, 0, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_r[0] !== 2'b10 || rd_d[0] !== 0) begin n_err++; $display("FAIL err_read_range: got %b/%h need 10/0", rd_r[0], rd_d[0]); end
  endtask

  task automatic test_stall;
    do_read(12'h055, 32'h4, 0, 3'b010, 2'b01, 5);
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (st_v[k] !== 1'b1 || st_d[k] !== m_scratch || st_r[k] !== 2'b00) begin
        n_err++; $display("FAIL stall%0d: got v=%b d=%h need 1 %h", k, st_v[k], st_d[k], m_scratch);
      end
    end
    n_chk++;
    if (rd_d[0] !== m_scratch) begin n_err++; $display("FAIL stall_final: got %h need %h", rd_d[0], m_scratch); end
  endtask

  task automatic test_cycles;
    logic [31:0] c1;
    int k1;
    do_read(12'h0, 32'h8, 0, 3'b010, 2'b01, 0);
    c1 = rd_d[0]; k1 = rd_cyc;
    repeat ($urandom_range(1, 20)) @(posedge i_clk);
    #1;
    do_read(12'h0, 32'h8, 0, 3'b010, 2'b01, 0);
    n_chk++;
    if (rd_d[0] - c1 !== 32'(rd_cyc - k1) || rd_r[0] !== 2'b00) begin
      n_err++; $display("FAIL cycles_delta: got %0d need %0d", rd_d[0] - c1, rd_cyc - k1);
    end
  endtask

  task automatic test_random;
    logic [31:0] r, a, ab;
    logic [11:0] id, bid;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst, resp, mresp;
    logic [33:0] e;
    for (int t = 0; t < 40; t++) begin
      r = $urandom;
      a = {r[31:12], ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00, 2'($urandom_range(0, 3)), 2'b00};
      id = 12'($urandom); len = 4'($urandom_range(0, 3));
      size = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        bit bl;
        logic [11:0] wid;
        wid = ($urandom_range(0, 7) == 0) ? id ^ 12'h001 : id;
        bl = $urandom_range(0, 9) == 0;
        for (int b = 0; b < 16; b++) begin tb_wd[b] = $urandom; tb_ws[b] = 4'($urandom); end
        model_write(id, a, len, size, burst, wid, bl, mresp);
        do_write(id, a, len, size, burst, wid, bl, resp, bid);
        n_chk++;
        if (resp !== mresp || bid !== id) begin n_err++; $display("FAIL rnd_write%0d: got %b/%h need %b/%h", t, resp, bid, mresp, id); end
      end else begin
        do_read(id, a, len, size, burst, 0);
        for (int b = 0; b <= int'(len); b++) begin
          ab = a + ((burst == 2'b00) ? 32'd0 : 32'(4 * b));
          e = model_read(ab, size, burst);
          n_chk++;
          if (rd_r[b] !== e[33:32] || (!(e[33:32] == 0 && ab[3:2] == 2) && rd_d[b] !== e[31:0]) ||
              rd_l[b] !== (b == int'(len)) || rd_id[b] !== id) begin
            n_err++; $display("FAIL rnd_read%0d.%0d: got %b/%h/%b need %b/%h/%b", t, b, rd_r[b], rd_d[b], rd_l[b],
                              e[33:32], e[31:0], b == int'(len));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp, mresp;
    logic [11:0] bid;
    tb_wd[0] = 32'h3C; tb_ws[0] = 4'hF;
    model_write(12'h7, 32'h0, 0, 3'b010, 2'b01, 12'h7, 0, mresp);
    do_write(12'h7, 32'h0, 0, 3'b010, 2'b01, 12'h7, 0, resp, bid);
    i_awvalid = 1; i_awid = 12'h9; i_awaddr = 32'h4; i_awlen = 4'd2; i_awsize = 3'b010; i_awburst = 2'b01;
    handshake(0);
    i_awvalid = 0;
    n_chk++;
    if (o_wready !== 1'b1 || o_led !== 8'h3C) begin n_err++; $display("FAIL mid_pre: got wready=%b led=%h need 1 3c", o_wready, o_led); end
    #2 i_rst_n = 0;
    #1;
    n_chk++;
    if ({o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast} !== 6'b0 || o_bid !== 0 || o_led !== 8'h55) begin
      n_err++; $display("FAIL mid_reset: got ctl=%b bid=%h led=%h need 0 0 55",
                        {o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast}, o_bid, o_led);
    end
    m_led = 8'h55; m_scratch = 0;
    @(posedge i_clk); #1;
    i_rst_n = 1;
    @(posedge i_clk); #1;
    tb_wd[0] = 32'hCAFEF00D; tb_ws[0] = 4'hF;
    model_write(12'h5, 32'h4, 0, 3'b010, 2'b01, 12'h5, 0, mresp);
    do_write(12'h5, 32'h4, 0, 3'b010, 2'b01, 12'h5, 0, resp, bid);
    do_read(12'h6, 32'h0, 1, 3'b010, 2'b01, 0);
    n_chk++;
    if (resp !== 2'b00 || bid !== 12'h5 || rd_d[0] !== 32'h55 || rd_d[1] !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL mid_after: got %b/%h %h %h need 00/005 55 cafef00d", resp, bid, rd_d[0], rd_d[1]);
    end
  endtask

  initial begin
    test_reset;
    test_id_read;
    test_strobe;
    test_incr;
    test_errors;
    test_stall;
    test_cycles;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
